// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and baud arithmetic for the transmitter and receiver.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  function automatic int cycles_per_bit(int clk_hz, int baud);
    return clk_hz / baud;
  endfunction
  function automatic int cnt_width(int cpb);
    return cpb > 1 ? $clog2(cpb) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: host handshake and serial line of the UART transmitter.
interface uart_tx_if;
  logic [7:0] data_i;
  logic       start_i;
  logic       busy_o;
  logic       done_o;
  logic       TXD_o;
  modport master (output data_i, start_i, input busy_o, done_o, TXD_o);
  modport slave (input data_i, start_i, output busy_o, done_o, TXD_o);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with clear; tick_o marks the last cycle of each bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CPB = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = cnt_width(CPB);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(CPB - 1);
  assign cnt_d = (clr_i || tick_o) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8N1/8N2 with start/busy handshake.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1/8E2).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int STOP_BITS = 1
) (
  input logic      clk_i,
  input logic      rst_i,
  uart_tx_if.slave bus
);
  localparam int CPB = cycles_per_bit(CLK_HZ, BAUD);
  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       stop_q, stop_d;
  logic       txd_q, txd_d;
  logic       done_q, done_d;
  logic       accept, tick;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif
  assign accept = state_q == IDLE && bus.start_i;
  uart_baud_gen #(.CPB(CPB)) u_baud (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (accept),
    .tick_o(tick)
  );
  // txd_d carries the level of the next bit so the line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (bus.start_i) begin
          shift_d = bus.data_i;
`ifdef UART_TX_PARITY_EN
          par_d   = ^bus.data_i;
`endif
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: if (tick) begin
        txd_d   = shift_q[0];
        shift_d = shift_q >> 1;
        idx_d   = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        idx_d   = idx_q + 3'd1;
        txd_d   = shift_q[0];
        shift_d = shift_q >> 1;
        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          txd_d   = par_q;
          state_d = PARITY;
`else
          txd_d   = 1'b1;
          stop_d  = 1'b0;
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        txd_d   = 1'b1;
        stop_d  = 1'b0;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        if (stop_q == 1'(STOP_BITS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else stop_d = 1'b1;
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  assign bus.busy_o = state_q != IDLE;
  assign bus.done_o = done_q;
  assign bus.TXD_o  = txd_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at 10 clocks per bit; a line receiver model pops expected bytes.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CPB  = 10;
  localparam int LAST = (10 + P) * CPB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] sb[$];
  uart_tx_if bus();
  uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .STOP_BITS(1)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  // Expected line level in cycle k after acceptance (k=1 is the first start-bit cycle).
  function automatic logic exp_txd(logic [7:0] b, int k);
    int i;
    i = (k - 1) / CPB;
    if (k < 1) return 1'b1;
    if (i == 0) return 1'b0;
    if (i <= 8) return b[3'(i - 1)];
    if (P == 1 && i == 9) return ^b;
    return 1'b1;
  endfunction
  int rx_cnt = 0;
  int rx_i = 0;
  logic rx_act = 1'b0;
  logic [7:0] rx_b = '0;
  logic [7:0] rx_exp = '0;
  logic rx_par = 1'b0;
  always @(negedge clk) begin
    if (rst) rx_act = 1'b0;
    else if (!rx_act) begin
      if (bus.TXD_o === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 1;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        rx_i = rx_cnt / CPB;
        if (rx_i == 0) begin
          n_tests++;
          if (bus.TXD_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_start: got %b, required 0", bus.TXD_o);
          end
        end else if (rx_i <= 8) rx_b[3'(rx_i - 1)] = bus.TXD_o;
        else if (rx_i < 9 + P) rx_par = bus.TXD_o;
        else begin
          n_tests++;
          if (bus.TXD_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_stop: got %b, required 1", bus.TXD_o);
          end
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL rx_unexpected: got frame %h, required none", rx_b);
          end else begin
            rx_exp = sb.pop_front();
            if (rx_b !== rx_exp) begin
              n_fail++;
              $display("FAIL rx_byte: got %h, required %h", rx_b, rx_exp);
            end
`ifdef UART_TX_PARITY_EN
            n_tests++;
            if (rx_par !== ^rx_exp) begin
              n_fail++;
              $display("FAIL rx_parity: got %b, required %b", rx_par, ^rx_exp);
            end
`endif
          end
          rx_act = 1'b0;
        end
      end
    end
  end
  // Request one frame; returns at the sample point of cycle 1.
  task automatic pulse(input logic [7:0] b, input bit push);
    bus.data_i  = b;
    bus.start_i = 1'b1;
    if (push) sb.push_back(b);
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask
  task automatic test_reset();
    bus.data_i  = '0;
    bus.start_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.TXD_o, bus.busy_o, bus.done_o} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d: txd/busy/done=%b%b%b, required 100", k, bus.TXD_o, bus.busy_o, bus.done_o);
      end
    end
  endtask
  task automatic test_single();
    pulse(8'hA5, 1'b1);
    for (int k = 1; k <= LAST + 10; k++) begin
      n_tests++;
      if (bus.TXD_o !== exp_txd(8'hA5, k) || bus.busy_o !== (k <= LAST) || bus.done_o !== (k == LAST + 1)) begin
        n_fail++;
        $display("FAIL single k=%0d: txd/busy/done=%b%b%b, required %b%b%b", k, bus.TXD_o, bus.busy_o, bus.done_o,
                 exp_txd(8'hA5, k), k <= LAST, k == LAST + 1);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back();
    int run;
    run = 0;
    pulse(8'h00, 1'b1);
    sb.push_back(8'hFF);
    bus.start_i = 1'b1;
    bus.data_i  = 8'hFF;
    for (int k = 1; k <= 2 * (LAST + 1) + 5; k++) begin
      n_tests++;
      if (bus.TXD_o !== (k <= LAST + 1 ? exp_txd(8'h00, k) : exp_txd(8'hFF, k - LAST - 1)) ||
          bus.done_o !== (k == LAST + 1 || k == 2 * LAST + 2)) begin
        n_fail++;
        $display("FAIL b2b k=%0d: txd/done=%b%b", k, bus.TXD_o, bus.done_o);
      end
      if (k == LAST + 2) begin
        n_tests++;
        if (run != CPB + 1) begin
          n_fail++;
          $display("FAIL b2b_gap: got %0d high clocks, required %0d", run, CPB + 1);
        end
        bus.start_i = 1'b0;
      end
      run = bus.TXD_o ? run + 1 : 0;
      @(negedge clk);
    end
  endtask
  task automatic test_reset_abort();
    pulse(8'h3C, 1'b0);
    for (int k = 1; k < 45; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.TXD_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_now: txd/busy=%b%b, required 10", bus.TXD_o, bus.busy_o);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.TXD_o, bus.busy_o, bus.done_o} !== 3'b100) begin
        n_fail++;
        $display("FAIL abort_idle k=%0d: txd/busy/done=%b%b%b, required 100", k, bus.TXD_o, bus.busy_o, bus.done_o);
      end
    end
    pulse(8'h3C, 1'b1);
    for (int k = 1; k <= LAST + 5; k++) begin
      n_tests++;
      if (bus.TXD_o !== exp_txd(8'h3C, k) || bus.done_o !== (k == LAST + 1)) begin
        n_fail++;
        $display("FAIL abort_resend k=%0d: txd/done=%b%b", k, bus.TXD_o, bus.done_o);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_ignore_busy();
    int dones;
    dones = 0;
    pulse(8'hC3, 1'b1);
    for (int k = 1; k <= LAST + 10; k++) begin
      n_tests++;
      if (bus.TXD_o !== exp_txd(8'hC3, k) || bus.busy_o !== (k <= LAST)) begin
        n_fail++;
        $display("FAIL ignore k=%0d: txd/busy=%b%b", k, bus.TXD_o, bus.busy_o);
      end
      dones += int'(bus.done_o);
      bus.data_i  = k == 30 ? 8'h12 : 8'hC3;
      bus.start_i = k == 30;
      @(negedge clk);
    end
    n_tests++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL ignore_done: got %0d pulses, required 1", dones);
    end
  endtask
`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] b, input logic par);
    int done_at;
    done_at = 0;
    pulse(b, 1'b1);
    for (int k = 1; k <= 120; k++) begin
      if (k == 95) begin
        n_tests++;
        if (bus.TXD_o !== par) begin
          n_fail++;
          $display("FAIL parity_bit %h: got %b, required %b", b, bus.TXD_o, par);
        end
      end
      if (bus.done_o === 1'b1 && done_at == 0) done_at = k;
      @(negedge clk);
    end
    n_tests++;
    if (done_at != 111) begin
      n_fail++;
      $display("FAIL parity_len %h: done at %0d, required 111", b, done_at);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_abort();
    test_ignore_busy();
`ifdef UART_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    repeat (20) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d frames outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
